// File: rtl/liteeth_sram_tx_reader.sv
// TX frame reader: turns byte-length descriptors into a 32-bit valid/ready stream
// read from the packet SRAM, hiding the one-cycle read latency behind a 2-entry buffer.
module liteeth_sram_tx_reader #(
    parameter int DEPTH      = 384,
    parameter int ADDR_WIDTH = 9,
    parameter int LEN_WIDTH  = 11
) (
    input  logic                  sys_clk,
    input  logic                  sys_rst,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [LEN_WIDTH-1:0]  cmd_len,
    output logic                  sram_csb,
    output logic [ADDR_WIDTH-1:0] sram_addr,
    input  logic [31:0]           sram_dout,
    output logic                  src_valid,
    input  logic                  src_ready,
    output logic [31:0]           src_data,
    output logic                  src_last,
    output logic [3:0]            src_last_be,
    output logic                  done,
    output logic                  err
);

    typedef enum logic [1:0] {IDLE = 2'd0, READ = 2'd1, DRAIN = 2'd2} state_t;

    localparam logic [LEN_WIDTH:0] MAX_LEN = (LEN_WIDTH+1)'(DEPTH * 4);

    function automatic logic [3:0] last_be_decode(input logic [1:0] tail_bytes);
        case (tail_bytes)
            2'd1:    return 4'b0001;
            2'd2:    return 4'b0010;
            2'd3:    return 4'b0100;
            default: return 4'b1000;
        endcase
    endfunction

    function automatic logic [ADDR_WIDTH-1:0] last_word_addr(input logic [LEN_WIDTH-1:0] len);
        logic [LEN_WIDTH:0] words;
        words = ({1'b0, len} + (LEN_WIDTH+1)'(3)) >> 2;
        words = words - (LEN_WIDTH+1)'(1);
        return words[ADDR_WIDTH-1:0];
    endfunction

    state_t                state, state_next;
    logic [ADDR_WIDTH-1:0] rd_cnt;
    logic [ADDR_WIDTH-1:0] last_addr;
    logic [1:0]            tail;
    logic                  vld_p1;
    logic                  last_p1;
    logic [31:0]           fifo_data [2];
    logic                  fifo_last [2];
    logic                  wr_ptr, rd_ptr;
    logic [1:0]            count;
    logic [1:0]            fill;
    logic                  accept, len_ok, issue, issue_last;
    logic                  head_valid, head_last;
    logic [31:0]           head_data;
    logic                  pop, push, pop_fifo;

    assign len_ok     = (cmd_len != '0) && ({1'b0, cmd_len} <= MAX_LEN);
    assign accept     = cmd_valid & cmd_ready;
    assign fill       = count + {1'b0, vld_p1};
    assign issue_last = (rd_cnt == last_addr);

    always_ff @(posedge sys_clk) begin
        if (sys_rst)
            state <= IDLE;
        else
            state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (accept && len_ok) state_next = READ;
            READ:    if (issue && issue_last) state_next = DRAIN;
            DRAIN:   if (pop && head_last) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        cmd_ready = 1'b0;
        issue     = 1'b0;
        case (state)
            IDLE:    cmd_ready = ~sys_rst;
            READ:    issue = (fill < 2'd2) & ~sys_rst;
            default: ;
        endcase
        sram_csb = ~issue;
    end

    assign sram_addr = rd_cnt;

    // Stage p1: SRAM word returning; it is offered directly when the buffer is empty.
    assign head_valid  = (count != 2'd0);
    assign head_data   = head_valid ? fifo_data[rd_ptr] : sram_dout;
    assign head_last   = head_valid ? fifo_last[rd_ptr] : last_p1;
    assign src_valid   = head_valid | vld_p1;
    assign src_data    = src_valid ? head_data : '0;
    assign src_last    = src_valid & head_last;
    assign src_last_be = src_last ? last_be_decode(tail) : 4'b0000;
    assign pop         = src_valid & src_ready;
    assign pop_fifo    = pop & head_valid;
    assign push        = vld_p1 & ~(pop & ~head_valid);

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            vld_p1 <= 1'b0;
            count  <= 2'd0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            rd_cnt <= '0;
            done   <= 1'b0;
            err    <= 1'b0;
        end else begin
            vld_p1 <= issue;
            done   <= (state == DRAIN) & pop & head_last;
            err    <= accept & ~len_ok;
            if (accept && len_ok)
                rd_cnt <= '0;
            else if (issue && !issue_last)
                rd_cnt <= rd_cnt + ADDR_WIDTH'(1);
            if (push)
                wr_ptr <= ~wr_ptr;
            if (pop_fifo)
                rd_ptr <= ~rd_ptr;
            case ({push, pop_fifo})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: ;
            endcase
        end
    end

    always_ff @(posedge sys_clk) begin
        last_p1 <= issue_last;
        if (push) begin
            fifo_data[wr_ptr] <= sram_dout;
            fifo_last[wr_ptr] <= last_p1;
        end
        if (accept && len_ok) begin
            last_addr <= last_word_addr(cmd_len);
            tail      <= cmd_len[1:0];
        end
    end

endmodule

// File: tb/tb_liteeth_sram_tx_reader.sv
// Directed bench for liteeth_sram_tx_reader with a behavioural one-cycle-latency SRAM.
module tb_liteeth_sram_tx_reader;

    localparam int DEPTH = 384;
    localparam int AW    = 9;
    localparam int LW    = 11;
    localparam int HMAX  = 800;

    logic          clk = 1'b0;
    logic          sys_rst = 1'b0;
    logic          cmd_valid = 1'b0;
    logic          cmd_ready;
    logic [LW-1:0] cmd_len = '0;
    logic          sram_csb;
    logic [AW-1:0] sram_addr;
    logic [31:0]   sram_dout = '0;
    logic          src_valid;
    logic          src_ready = 1'b1;
    logic [31:0]   src_data;
    logic          src_last;
    logic [3:0]    src_last_be;
    logic          done;
    logic          err;

    always #5 clk = ~clk;

    liteeth_sram_tx_reader #(.DEPTH(DEPTH), .ADDR_WIDTH(AW), .LEN_WIDTH(LW)) dut (
        .sys_clk(clk), .sys_rst(sys_rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_len(cmd_len),
        .sram_csb(sram_csb), .sram_addr(sram_addr), .sram_dout(sram_dout),
        .src_valid(src_valid), .src_ready(src_ready), .src_data(src_data),
        .src_last(src_last), .src_last_be(src_last_be), .done(done), .err(err)
    );

    logic [31:0] mem [DEPTH];
    always @(posedge clk) if (!sram_csb) sram_dout <= mem[sram_addr];

    function automatic logic [31:0] pat(input int i);
        return 32'h5A000000 ^ (32'(i) * 32'h00010007) ^ 32'h00001111;
    endfunction

    int n_checks = 0;
    int n_errors = 0;

    int  cmd_q[$];
    bit  rand_ready = 1'b0;
    int  rst_at = 0;

    int          acc_cyc[$], rd_addr[$], rd_cyc[$], done_cyc[$], err_cyc[$], beat_cyc[$];
    logic [31:0] beat_data[$];
    logic        beat_last[$];
    logic [3:0]  beat_be[$];
    bit          valid_hist [HMAX];
    bit          csb_hist [HMAX];
    int          stall_bad, occ_bad;

    // Drives one cycle per iteration at the negedge and records what the DUT did.
    task automatic run(input int ncyc);
        logic        stalled;
        logic [31:0] pd;
        logic        pl;
        logic [3:0]  pb;
        int          issued, accepted;
        acc_cyc.delete(); rd_addr.delete(); rd_cyc.delete(); done_cyc.delete();
        err_cyc.delete(); beat_cyc.delete(); beat_data.delete(); beat_last.delete(); beat_be.delete();
        stall_bad = 0; occ_bad = 0; stalled = 1'b0; issued = 0; accepted = 0;
        pd = '0; pl = 1'b0; pb = '0;
        for (int cyc = 1; cyc <= ncyc; cyc++) begin
            @(negedge clk);
            sys_rst   = (cyc == rst_at);
            cmd_valid = (cmd_q.size() > 0);
            cmd_len   = cmd_valid ? LW'(cmd_q[0]) : '0;
            src_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            #1;
            valid_hist[cyc] = src_valid;
            csb_hist[cyc]   = sram_csb;
            if (cmd_valid && cmd_ready) begin
                acc_cyc.push_back(cyc);
                void'(cmd_q.pop_front());
            end
            if (!sram_csb) begin
                rd_addr.push_back(int'(sram_addr));
                rd_cyc.push_back(cyc);
                if (issued - accepted >= 2) occ_bad++;
                issued++;
            end
            if (stalled && (!src_valid || src_data !== pd || src_last !== pl || src_last_be !== pb))
                stall_bad++;
            if (src_valid && src_ready) begin
                beat_cyc.push_back(cyc);
                beat_data.push_back(src_data);
                beat_last.push_back(src_last);
                beat_be.push_back(src_last_be);
                accepted++;
            end
            stalled = src_valid && !src_ready;
            pd = src_data; pl = src_last; pb = src_last_be;
            if (done) done_cyc.push_back(cyc);
            if (err) err_cyc.push_back(cyc);
        end
        sys_rst = 1'b0;
    endtask

    task automatic test_reset();
        sys_rst = 1'b1; cmd_valid = 1'b0; src_ready = 1'b1;
        @(negedge clk); @(negedge clk); #1;
        n_checks++; if (cmd_ready !== 1'b0) begin n_errors++; $display("FAIL rst_cmd_ready_during: got %0b want 0", cmd_ready); end
        @(negedge clk); sys_rst = 1'b0; #1;
        n_checks++; if (src_valid !== 1'b0) begin n_errors++; $display("FAIL rst_src_valid: got %0b want 0", src_valid); end
        n_checks++; if (src_last !== 1'b0) begin n_errors++; $display("FAIL rst_src_last: got %0b want 0", src_last); end
        n_checks++; if (src_last_be !== 4'b0000) begin n_errors++; $display("FAIL rst_src_last_be: got %b want 0000", src_last_be); end
        n_checks++; if (src_data !== 32'h0) begin n_errors++; $display("FAIL rst_src_data: got %h want 0", src_data); end
        n_checks++; if (sram_csb !== 1'b1) begin n_errors++; $display("FAIL rst_sram_csb: got %0b want 1", sram_csb); end
        n_checks++; if (sram_addr !== '0) begin n_errors++; $display("FAIL rst_sram_addr: got %0d want 0", sram_addr); end
        n_checks++; if (done !== 1'b0) begin n_errors++; $display("FAIL rst_done: got %0b want 0", done); end
        n_checks++; if (err !== 1'b0) begin n_errors++; $display("FAIL rst_err: got %0b want 0", err); end
        n_checks++; if (cmd_ready !== 1'b1) begin n_errors++; $display("FAIL rst_cmd_ready_idle: got %0b want 1", cmd_ready); end
    endtask

    task automatic test_len64();
        int t, bad;
        rand_ready = 1'b0; cmd_q = {64};
        run(30);
        t = (acc_cyc.size() > 0) ? acc_cyc[0] : 1;
        n_checks++; if (acc_cyc.size() !== 1) begin n_errors++; $display("FAIL l64_accepts: got %0d want 1", acc_cyc.size()); end
        n_checks++; if (rd_addr.size() !== 16) begin n_errors++; $display("FAIL l64_reads: got %0d want 16", rd_addr.size()); end
        bad = 0;
        for (int i = 0; i < rd_addr.size() && i < 16; i++)
            if (rd_addr[i] != i || rd_cyc[i] != t + 1 + i) bad++;
        n_checks++; if (bad !== 0) begin n_errors++; $display("FAIL l64_read_seq: got %0d bad reads want 0", bad); end
        n_checks++; if (beat_data.size() !== 16) begin n_errors++; $display("FAIL l64_beats: got %0d want 16", beat_data.size()); end
        bad = 0;
        for (int i = 0; i < beat_data.size() && i < 16; i++)
            if (beat_cyc[i] != t + 2 + i || beat_data[i] !== pat(i) || beat_last[i] !== (i == 15) ||
                beat_be[i] !== ((i == 15) ? 4'b1000 : 4'b0000)) bad++;
        n_checks++; if (bad !== 0) begin n_errors++; $display("FAIL l64_beat_seq: got %0d bad beats want 0", bad); end
        n_checks++; if (done_cyc.size() !== 1 || done_cyc[0] != t + 18) begin
            n_errors++; $display("FAIL l64_done: got %0d pulses first at %0d want 1 at %0d", done_cyc.size(),
                                 (done_cyc.size() > 0) ? done_cyc[0] : -1, t + 18); end
    endtask

    task automatic test_short_tails();
        rand_ready = 1'b0; cmd_q = {5};
        run(10);
        n_checks++; if (beat_data.size() !== 2) begin n_errors++; $display("FAIL len5_beats: got %0d want 2", beat_data.size()); end
        if (beat_data.size() == 2) begin
            n_checks++; if (beat_data[0] !== pat(0) || beat_data[1] !== pat(1)) begin
                n_errors++; $display("FAIL len5_data: got %h %h want %h %h", beat_data[0], beat_data[1], pat(0), pat(1)); end
            n_checks++; if (beat_last[0] !== 1'b0 || beat_be[0] !== 4'b0000) begin
                n_errors++; $display("FAIL len5_first: got last=%0b be=%b want 0 0000", beat_last[0], beat_be[0]); end
            n_checks++; if (beat_last[1] !== 1'b1 || beat_be[1] !== 4'b0001) begin
                n_errors++; $display("FAIL len5_last_be: got last=%0b be=%b want 1 0001", beat_last[1], beat_be[1]); end
        end
        n_checks++; if (done_cyc.size() !== 1) begin n_errors++; $display("FAIL len5_done: got %0d want 1", done_cyc.size()); end
        cmd_q = {7};
        run(10);
        n_checks++; if (beat_data.size() !== 2) begin n_errors++; $display("FAIL len7_beats: got %0d want 2", beat_data.size()); end
        if (beat_data.size() == 2) begin
            n_checks++; if (beat_last[1] !== 1'b1 || beat_be[1] !== 4'b0100) begin
                n_errors++; $display("FAIL len7_last_be: got last=%0b be=%b want 1 0100", beat_last[1], beat_be[1]); end
        end
    endtask

    task automatic test_max_frame();
        int t, bad, n;
        rand_ready = 1'b0; cmd_q = {1536};
        run(395);
        t = (acc_cyc.size() > 0) ? acc_cyc[0] : 1;
        n = beat_data.size();
        n_checks++; if (n !== 384) begin n_errors++; $display("FAIL max_beats: got %0d want 384", n); end
        bad = 0;
        for (int i = 0; i < n && i < 384; i++)
            if (beat_data[i] !== pat(i) || beat_last[i] !== (i == 383)) bad++;
        n_checks++; if (bad !== 0) begin n_errors++; $display("FAIL max_data: got %0d bad beats want 0", bad); end
        n_checks++; if (rd_addr.size() !== 384 || rd_addr[rd_addr.size()-1] != 383) begin
            n_errors++; $display("FAIL max_last_addr: got %0d reads ending %0d want 384 ending 383", rd_addr.size(),
                                 (rd_addr.size() > 0) ? rd_addr[rd_addr.size()-1] : -1); end
        n_checks++; if (n < 1 || beat_be[n-1] !== 4'b1000) begin
            n_errors++; $display("FAIL max_last_be: got %b want 1000", (n > 0) ? beat_be[n-1] : 4'bxxxx); end
        n_checks++; if (done_cyc.size() !== 1 || done_cyc[0] != t + 386) begin
            n_errors++; $display("FAIL max_done: got %0d pulses first at %0d want 1 at %0d", done_cyc.size(),
                                 (done_cyc.size() > 0) ? done_cyc[0] : -1, t + 386); end
    endtask

    task automatic test_reject();
        rand_ready = 1'b0; cmd_q = {0, 1537};
        run(8);
        n_checks++; if (acc_cyc.size() !== 2 || acc_cyc[0] != 1 || acc_cyc[1] != 2) begin
            n_errors++; $display("FAIL rej_cmd_ready: got %0d accepts want 2 at cycles 1,2", acc_cyc.size()); end
        n_checks++; if (err_cyc.size() !== 2 || err_cyc[0] != 2 || err_cyc[1] != 3) begin
            n_errors++; $display("FAIL rej_err: got %0d pulses first at %0d want 2 at cycles 2,3", err_cyc.size(),
                                 (err_cyc.size() > 0) ? err_cyc[0] : -1); end
        n_checks++; if (rd_addr.size() !== 0) begin n_errors++; $display("FAIL rej_reads: got %0d want 0", rd_addr.size()); end
        n_checks++; if (beat_data.size() !== 0 || done_cyc.size() !== 0) begin
            n_errors++; $display("FAIL rej_beats: got %0d beats %0d done want 0 0", beat_data.size(), done_cyc.size()); end
    endtask

    task automatic test_backpressure();
        int bad, n;
        rand_ready = 1'b1; cmd_q = {40};
        run(100);
        rand_ready = 1'b0;
        n = beat_data.size();
        n_checks++; if (n !== 10) begin n_errors++; $display("FAIL bp_beats: got %0d want 10", n); end
        bad = 0;
        for (int i = 0; i < n && i < 10; i++)
            if (beat_data[i] !== pat(i) || beat_last[i] !== (i == 9) ||
                beat_be[i] !== ((i == 9) ? 4'b1000 : 4'b0000)) bad++;
        n_checks++; if (bad !== 0) begin n_errors++; $display("FAIL bp_order: got %0d bad beats want 0", bad); end
        n_checks++; if (stall_bad !== 0) begin n_errors++; $display("FAIL bp_stable: got %0d unstable cycles want 0", stall_bad); end
        n_checks++; if (occ_bad !== 0) begin n_errors++; $display("FAIL bp_occupancy: got %0d overfull issues want 0", occ_bad); end
        n_checks++; if (rd_addr.size() !== 10 || done_cyc.size() !== 1) begin
            n_errors++; $display("FAIL bp_reads_done: got %0d reads %0d done want 10 1", rd_addr.size(), done_cyc.size()); end
    endtask

    task automatic test_reset_midframe();
        int n;
        rand_ready = 1'b0; cmd_q = {40};
        rst_at = 6;
        run(20);
        rst_at = 0;
        n_checks++; if (beat_data.size() !== 4) begin n_errors++; $display("FAIL mrst_beats: got %0d want 4", beat_data.size()); end
        n_checks++; if (valid_hist[7] !== 1'b0) begin n_errors++; $display("FAIL mrst_src_valid: got %0b want 0", valid_hist[7]); end
        n_checks++; if (csb_hist[7] !== 1'b1) begin n_errors++; $display("FAIL mrst_sram_csb: got %0b want 1", csb_hist[7]); end
        n_checks++; if (done_cyc.size() !== 0) begin n_errors++; $display("FAIL mrst_done: got %0d want 0", done_cyc.size()); end
        cmd_q = {8};
        run(10);
        n = beat_data.size();
        n_checks++; if (n !== 2) begin n_errors++; $display("FAIL mrst_next_beats: got %0d want 2", n); end
        if (n == 2) begin
            n_checks++; if (beat_data[0] !== pat(0) || beat_data[1] !== pat(1) || beat_last[1] !== 1'b1 || beat_be[1] !== 4'b1000) begin
                n_errors++; $display("FAIL mrst_next_data: got %h %h be=%b want %h %h be=1000",
                                     beat_data[0], beat_data[1], beat_be[1], pat(0), pat(1)); end
        end
    endtask

    task automatic test_back_to_back();
        int bad, n;
        int exp_addr[5] = '{0, 1, 0, 1, 2};
        rand_ready = 1'b0; cmd_q = {8, 12};
        run(20);
        n_checks++; if (acc_cyc.size() !== 2 || acc_cyc[0] != 1 || acc_cyc[1] != 5) begin
            n_errors++; $display("FAIL b2b_accepts: got %0d accepts second at %0d want 2 second at 5", acc_cyc.size(),
                                 (acc_cyc.size() > 1) ? acc_cyc[1] : -1); end
        n_checks++; if (done_cyc.size() !== 2 || done_cyc[0] != 5 || done_cyc[1] != 10) begin
            n_errors++; $display("FAIL b2b_done: got %0d pulses first at %0d want 2 at 5,10", done_cyc.size(),
                                 (done_cyc.size() > 0) ? done_cyc[0] : -1); end
        bad = (rd_addr.size() == 5) ? 0 : 1;
        for (int i = 0; i < rd_addr.size() && i < 5; i++) if (rd_addr[i] != exp_addr[i]) bad++;
        n_checks++; if (bad !== 0) begin n_errors++; $display("FAIL b2b_addr: got %0d bad reads of %0d want 0 of 5", bad, rd_addr.size()); end
        n = beat_data.size();
        bad = (n == 5) ? 0 : 1;
        for (int i = 0; i < n && i < 5; i++)
            if (beat_data[i] !== pat(exp_addr[i]) || beat_last[i] !== (i == 1 || i == 4)) bad++;
        n_checks++; if (bad !== 0) begin n_errors++; $display("FAIL b2b_beats: got %0d bad of %0d beats want 0 of 5", bad, n); end
        n_checks++; if (n < 3 || beat_cyc[2] != 7) begin
            n_errors++; $display("FAIL b2b_restart_cycle: got %0d want 7", (n > 2) ? beat_cyc[2] : -1); end
    endtask

    initial begin
        for (int i = 0; i < DEPTH; i++) mem[i] = pat(i);
        test_reset();
        test_len64();
        test_short_tails();
        test_max_frame();
        test_reject();
        test_backpressure();
        test_reset_midframe();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/liteeth_sram_tx_reader.md
# liteeth_sram_tx_reader

Frame reader for the TX side of the LiteEth MAC buffer. It consumes read descriptors (byte length) and streams one 32-bit word per beat out of the 32x384 dual-port packet SRAM's read-only port. Its output is a valid/ready stream with `last` and `last_be`, feeding the MAC TX datapath (padding/CRC stage). The block absorbs the SRAM's one-cycle read latency and downstream backpressure without bubbles.

## Interface
- `DEPTH`, 384: SRAM words; the maximum frame is DEPTH*4 = 1536 bytes.
- `ADDR_WIDTH`, 9: SRAM address width.
- `LEN_WIDTH`, 11: width of the byte-length field.
- `sys_clk` in 1: the single clock. Also drives the SRAM read-port clock.
- `sys_rst` in 1: synchronous, active-high reset.
- `cmd_valid` in 1: descriptor valid.
- `cmd_ready` out 1: descriptor accepted when high together with `cmd_valid`.
- `cmd_len` in LEN_WIDTH: frame length in bytes.
- `sram_csb` out 1: SRAM read chip select, active low.
- `sram_addr` out ADDR_WIDTH: SRAM read address.
- `sram_dout` in 32: SRAM read data, valid one cycle after `sram_csb` is low.
- `src_valid` out 1: output beat valid.
- `src_ready` in 1: downstream accepts the beat.
- `src_data` out 32: frame word, little-endian; byte 0 is in [7:0].
- `src_last` out 1: final beat of the frame.
- `src_last_be` out 4: one-hot marker of the last valid byte. It is 0 on non-last beats.
- `done` out 1: one-cycle pulse when the last beat is accepted.
- `err` out 1: one-cycle pulse when a descriptor is rejected.

## Operation
- States: IDLE, READ, DRAIN.
  - IDLE: `cmd_ready = ~sys_rst`.
  - READ and DRAIN: `cmd_ready = 0`.
- Descriptor acceptance in IDLE:
  - If `cmd_len == 0` or `cmd_len > DEPTH*4`: pulse `err` the next cycle, stay in IDLE, issue no reads and no beats.
  - Otherwise latch the word count `nwords = (cmd_len+3)>>2` and `tail = cmd_len[1:0]`, clear the read address counter, and go to READ.
- READ:
  - Issue a read (`sram_csb = 0`, `sram_addr = rd_cnt`, then `rd_cnt++`) only when `(output buffer occupancy + reads in flight) < 2`.
  - After issuing word `nwords-1`, go to DRAIN.
- DRAIN: wait until the beat marked `last` is accepted, then go to IDLE and pulse `done` in that same transition cycle.
- Output buffer:
  - A 2-entry FIFO holds returned SRAM words, each tagged with a last flag.
  - A word is written into the FIFO in the cycle after its read issue.
  - Any word of a frame, including the last, leaves the FIFO only on `src_valid & src_ready`.
- `src_last_be` on the last beat, decoded from `tail`:
  - 1 → 0001
  - 2 → 0010
  - 3 → 0100
  - 0 → 1000
- `src_data` is passed through unmodified. Bytes beyond `tail` are don't-care.
- `sram_addr` wraps never: `rd_cnt` tops at nwords-1 ≤ DEPTH-1.
- `src_valid` never drops while held by backpressure. `src_data`, `src_last` and `src_last_be` are stable while `src_valid & ~src_ready`.
- Reset mid-frame:
  - The next cycle is IDLE with the FIFO empty, `src_valid = 0` and `sram_csb = 1`.
  - In-flight read data arriving after reset is discarded.
  - No `done` is produced.

## Timing
- Reset values:
  - `src_valid` 0
  - `src_last` 0
  - `src_last_be` 0
  - `src_data` 0
  - `sram_csb` 1
  - `sram_addr` 0
  - `done` 0
  - `err` 0
  - state IDLE
- Descriptor handshake at cycle T: first read issued at T+1, first `src_valid` at T+2.
- Throughput: with `src_ready` held high, one beat per cycle with no bubbles. A frame of N words has its last beat at T+N+1 and `done` at T+N+2.
- Backpressure: when `src_ready` is released after a stall, beats resume in the same cycle. Read issue resumes within one cycle, and there are no bubbles after the first beat.
- A new descriptor can be accepted in the cycle `done` is high, giving a one-cycle IDLE gap between frames.
- `err` is asserted at T+1 for a rejected descriptor at T. `cmd_ready` stays high.

## Test plan
- Reset, then `cmd_len = 64` with `src_ready = 1`:
  - reads at addr 0..15 on consecutive cycles;
  - 16 beats from T+2 to T+17;
  - `src_last` and `src_last_be = 1000` on beat 15;
  - `done` at T+18.
- `cmd_len = 5`: 2 beats; the second beat has `last = 1` and `src_last_be = 0001`. With `cmd_len = 7`, `last_be = 0100`.
- `cmd_len = 1536`: 384 beats, last address 383, `last_be = 1000`. With `cmd_len = 0` or 1537: `err` pulse, no `sram_csb` activity, no beats.
- Random `src_ready` (50%) on a 40-byte frame:
  - data order matches the SRAM preload;
  - outputs are stable during stalls;
  - no word is duplicated or dropped;
  - at most 2 words are buffered or in flight.
- `sys_rst` asserted for 1 cycle mid-frame (beat 3 of 10): next cycle `src_valid = 0` and `sram_csb = 1`, no `done`. A following `cmd_len = 8` frame outputs words 0 and 1 correctly.
- Back-to-back descriptors (`cmd_valid` held) of 8 and 12 bytes: the second is accepted in the `done` cycle of the first, and its beats restart at address 0.
